reg_bus_sequencer: RTL

REG_BUS_SEQUENCER -- requirements
Module: reg_bus_sequencer

---
 rtl/reg_bus_sequencer.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/reg_bus_sequencer.sv
// reg_bus_sequencer: round-robin sequencer for register-to-register transfers
// on a shared 4-bit tri-state bus. Each transfer drives the source register
// onto the bus (DRIVE), then holds it while the destination loads (LATCH).
// All bus-facing strobes and handshake outputs come straight from flops.
// Optional build macro REG_BUS_TURNAROUND_EN adds a one-cycle, bus-idle TURN
// state after LATCH so drivers can release the bus before the next transfer.
module reg_bus_sequencer #(
    parameter int NREG = 8,
    parameter int NREQ = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*3-1:0] src,
    input  logic [NREQ*3-1:0] dst,
    output logic [NREQ-1:0]   ack,
    output logic              err,
    output logic              busy,
    output logic [NREG-1:0]   oe_n,
    output logic [NREG-1:0]   ld_n
);

    localparam int RRW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        LATCH = 2'd2,
        TURN  = 2'd3
    } state_t;

    state_t          state;
    state_t          state_d;
    logic [RRW-1:0]  rr;
    logic [RRW-1:0]  rr_d;

    // Transfer captured at grant; later src/dst/req changes are ignored.
    logic [RRW-1:0]  cur_idx;
    logic [2:0]      cur_src;
    logic [2:0]      cur_dst;

    // Next values of the registered outputs.
    logic [NREQ-1:0] ack_d;
    logic            err_d;
    logic            busy_d;
    logic [NREG-1:0] oe_d;
    logic [NREG-1:0] ld_d;

    // Arbitration results.
    logic [NREQ-1:0] req_eff;
    logic            found;
    logic [RRW-1:0]  gnt;
    logic [2:0]      gnt_src;
    logic [2:0]      gnt_dst;
    logic            gnt_bad;
    logic            grant_load;
    int              scan;

    // Round-robin search starting at rr. A requester whose ack is high this
    // cycle is still allowed to show its old req level, so it is masked to
    // avoid granting the same request twice after a rejected transfer.
    always_comb begin
        req_eff = req & ~ack;
        found   = 1'b0;
        gnt     = '0;
        scan    = 0;
        for (int k = 0; k < NREQ; k++) begin
            scan = (int'(rr) + k) % NREQ;
            if (!found && req_eff[scan]) begin
                found = 1'b1;
                gnt   = RRW'(scan);
            end
        end
    end

    assign gnt_src = src[int'(gnt)*3 +: 3];
    assign gnt_dst = dst[int'(gnt)*3 +: 3];

    // Same-register or out-of-range transfers are rejected without bus activity.
    assign gnt_bad = (gnt_src == gnt_dst)
                   || (int'(gnt_src) >= NREG)
                   || (int'(gnt_dst) >= NREG);

    assign grant_load = (state == IDLE) && found;

    // Next-state and next-output decode; outputs describe the cycle being entered.
    always_comb begin
        state_d = state;
        rr_d    = rr;
        ack_d   = '0;
        err_d   = 1'b0;
        busy_d  = 1'b0;
        oe_d    = '1;
        ld_d    = '1;
        case (state)
            IDLE: begin
                if (found) begin
                    rr_d = RRW'((int'(gnt) + 1) % NREQ);
                    if (gnt_bad) begin
                        state_d = IDLE;
                        ack_d   = NREQ'(1) << gnt;
                        err_d   = 1'b1;
                    end else begin
                        state_d = DRIVE;
                        busy_d  = 1'b1;
                        oe_d    = ~(NREG'(1) << gnt_src);
                    end
                end
            end
            DRIVE: begin
                state_d = LATCH;
                busy_d  = 1'b1;
                oe_d    = ~(NREG'(1) << cur_src);
                ld_d    = ~(NREG'(1) << cur_dst);
                ack_d   = NREQ'(1) << cur_idx;
            end
            LATCH: begin
`ifdef REG_BUS_TURNAROUND_EN
                state_d = TURN;
                busy_d  = 1'b1;
`else
                state_d = IDLE;
`endif
            end
            TURN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control state and registered outputs; reset puts the bus fully idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            rr    <= '0;
            ack   <= '0;
            err   <= 1'b0;
            busy  <= 1'b0;
            oe_n  <= '1;
            ld_n  <= '1;
        end else begin
            state <= state_d;
            rr    <= rr_d;
            ack   <= ack_d;
            err   <= err_d;
            busy  <= busy_d;
            oe_n  <= oe_d;
            ld_n  <= ld_d;
        end
    end

    // Capture the granted transfer's requester and register indices.
    always_ff @(posedge clk) begin
        if (grant_load) begin
            cur_idx <= gnt;
            cur_src <= gnt_src;
            cur_dst <= gnt_dst;
        end
    end

endmodule
